// File: rtl/flappy_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | flappy_pkg: shared state encoding, widths and default bounds     |
// | Rev 1.0 - initial release                                        |
// +------------------------------------------------------------------+
package flappy_pkg;

  localparam int STATE_W   = 2;
  localparam int SCORE_W   = 8;
  localparam int POS_W     = 10;
  localparam int DEB_CNT_W = 20;

  localparam logic [STATE_W-1:0] ST_INIT  = 2'd0;
  localparam logic [STATE_W-1:0] ST_READY = 2'd1;
  localparam logic [STATE_W-1:0] ST_PLAY  = 2'd2;
  localparam logic [STATE_W-1:0] ST_DEAD  = 2'd3;

  localparam logic signed [POS_W-1:0] Y_MIN_DEFAULT = 10'sd0;
  localparam logic signed [POS_W-1:0] Y_MAX_DEFAULT = 10'sd470;

  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/flappy_game_ctrl_button_debounce.sv
`default_nettype none
// +------------------------------------------------------------------+
// | button_debounce: 2-flop synchroniser, stability counter and      |
// | registered rising-edge detector for the jump button              |
// | Rev 1.0 - initial release                                        |
// +------------------------------------------------------------------+
module button_debounce
  import flappy_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic Clk,
  input  logic reset,
  input  logic BtnRaw,
  output logic Level,
  output logic Press
);

  localparam logic [DEB_CNT_W-1:0] C_CNT_LAST = DEB_CNT_W'(DEBOUNCE_CYCLES - 1);

  logic                 r_sync1;
  logic                 r_sync2;
  logic                 r_level;
  logic                 r_level_d;
  logic                 r_press;
  logic [DEB_CNT_W-1:0] r_cnt;

  always_ff @(posedge Clk) begin
    if (reset) begin
      r_sync1   <= 1'b0;
      r_sync2   <= 1'b0;
      r_level   <= 1'b0;
      r_level_d <= 1'b0;
      r_press   <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_sync1   <= BtnRaw;
      r_sync2   <= r_sync1;
      r_level_d <= r_level;
      r_press   <= r_level & ~r_level_d;
      // Any cycle where the synced level agrees with the output restarts the run.
      if (r_sync2 != r_level) begin
        if (r_cnt == C_CNT_LAST) begin
          r_level <= r_sync2;
          r_cnt   <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign Level = r_level;
  assign Press = r_press;

endmodule
`default_nettype wire

// File: rtl/flappy_game_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | flappy_game_ctrl: game state machine, per-frame physics gating,  |
// | jump request merging and saturating score                        |
// | Rev 1.0 - initial release                                        |
// +------------------------------------------------------------------+
module flappy_game_ctrl
  import flappy_pkg::*;
#(
  parameter int                       DEBOUNCE_CYCLES = 500000,
  parameter logic signed [POS_W-1:0]  Y_MIN           = Y_MIN_DEFAULT,
  parameter logic signed [POS_W-1:0]  Y_MAX           = Y_MAX_DEFAULT
) (
  input  logic                     Clk,
  input  logic                     reset,
  input  logic                     Start,
  input  logic                     Ack,
  input  logic                     BtnRaw,
  input  logic                     FrameTick,
  input  logic                     Collide,
  input  logic                     PipePassed,
  input  logic signed [POS_W-1:0]  Bird_Y,
  output logic                     PhysReset,
  output logic                     PhysStep,
  output logic                     JumpReq,
  output logic [SCORE_W-1:0]       Score,
  output logic                     q_Init,
  output logic                     q_Ready,
  output logic                     q_Play,
  output logic                     q_Dead
);

  logic                 w_btn_level;
  logic                 w_btn_press;
  logic                 w_press;
  logic                 w_dead;

  logic [STATE_W-1:0]   r_state;
  logic [STATE_W-1:0]   w_state_next;
  logic                 r_pending;
  logic                 w_pending_next;
  logic                 w_step_next;
  logic                 w_jump_next;
  logic                 w_phys_reset_next;
  logic [SCORE_W-1:0]   w_score_next;

  button_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_button_debounce (
    .Clk    (Clk),
    .reset  (reset),
    .BtnRaw (BtnRaw),
    .Level  (w_btn_level),
    .Press  (w_btn_press)
  );

  // Level is always high alongside a Press; the AND only documents that.
  assign w_press = w_btn_press & w_btn_level;
  assign w_dead  = Collide || (Bird_Y < Y_MIN) || (Bird_Y > Y_MAX);

  always_ff @(posedge Clk) begin
    if (reset) begin
      r_state   <= ST_INIT;
      r_pending <= 1'b0;
      PhysReset <= 1'b1;
      PhysStep  <= 1'b0;
      JumpReq   <= 1'b0;
      Score     <= '0;
      q_Init    <= 1'b1;
      q_Ready   <= 1'b0;
      q_Play    <= 1'b0;
      q_Dead    <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_pending <= w_pending_next;
      PhysReset <= w_phys_reset_next;
      PhysStep  <= w_step_next;
      JumpReq   <= w_jump_next;
      Score     <= w_score_next;
      q_Init    <= (w_state_next == ST_INIT);
      q_Ready   <= (w_state_next == ST_READY);
      q_Play    <= (w_state_next == ST_PLAY);
      q_Dead    <= (w_state_next == ST_DEAD);
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_INIT:  if (Start)   w_state_next = ST_READY;
      ST_READY: if (w_press) w_state_next = ST_PLAY;
      ST_PLAY:  if (w_dead)  w_state_next = ST_DEAD;
      ST_DEAD:  if (Ack)     w_state_next = ST_INIT;
      default:               w_state_next = ST_INIT;
    endcase
  end

  always_comb begin
    w_pending_next = r_pending;
    w_step_next    = 1'b0;
    w_jump_next    = 1'b0;
    w_score_next   = Score;
    case (r_state)
      ST_INIT:  w_pending_next = 1'b0;
      ST_READY: if (w_press) w_pending_next = 1'b1;
      ST_PLAY: begin
        if (PipePassed) w_score_next = sat_inc(Score);
        // A dying cycle issues neither step nor jump, even on a frame tick.
        if (!w_dead) begin
          if (FrameTick) begin
            w_jump_next    = r_pending | w_press;
            w_step_next    = ~(r_pending | w_press);
            w_pending_next = 1'b0;
          end else if (w_press) begin
            w_pending_next = 1'b1;
          end
        end
      end
      default: ;
    endcase
    if (w_state_next == ST_INIT) begin
      w_score_next   = '0;
      w_pending_next = 1'b0;
    end
    w_phys_reset_next = (w_state_next == ST_INIT) || (w_state_next == ST_READY);
  end

endmodule
`default_nettype wire

// File: tb/tb_flappy_game_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_flappy_game_ctrl: randomized bench against a rule-level model |
// | Rev 1.0 - initial release                                        |
// +------------------------------------------------------------------+
module tb_flappy_game_ctrl;

  localparam int D    = 4;
  localparam int YMIN = 0;
  localparam int YMAX = 470;

  logic              Clk = 1'b0;
  logic              reset = 1'b0;
  logic              Start = 1'b0;
  logic              Ack = 1'b0;
  logic              BtnRaw = 1'b0;
  logic              FrameTick = 1'b0;
  logic              Collide = 1'b0;
  logic              PipePassed = 1'b0;
  logic signed [9:0] Bird_Y = '0;
  logic              PhysReset, PhysStep, JumpReq;
  logic [7:0]        Score;
  logic              q_Init, q_Ready, q_Play, q_Dead;

  flappy_game_ctrl #(
    .DEBOUNCE_CYCLES (D),
    .Y_MIN           (10'sd0),
    .Y_MAX           (10'sd470)
  ) dut (
    .Clk        (Clk),
    .reset      (reset),
    .Start      (Start),
    .Ack        (Ack),
    .BtnRaw     (BtnRaw),
    .FrameTick  (FrameTick),
    .Collide    (Collide),
    .PipePassed (PipePassed),
    .Bird_Y     (Bird_Y),
    .PhysReset  (PhysReset),
    .PhysStep   (PhysStep),
    .JumpReq    (JumpReq),
    .Score      (Score),
    .q_Init     (q_Init),
    .q_Ready    (q_Ready),
    .q_Play     (q_Play),
    .q_Dead     (q_Dead)
  );

  always #5 Clk = ~Clk;

  int n_cmp = 0;
  int n_err = 0;

  // Model: game phase 0=init 1=ready 2=play 3=dead
  int m_st, m_score;
  bit m_pend, m_step, m_jump, m_preset;
  bit m_press, m_deb, m_deb_d;
  bit rawq[$];
  bit syncq[$];

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_step(input bit rst, st, ak, btn, tk, col, pp, input int y);
    int  nst;
    bit  dead, p, s, flip;
    if (rst) begin
      m_st = 0; m_score = 0; m_pend = 0; m_step = 0; m_jump = 0; m_preset = 1;
      m_press = 0; m_deb = 0; m_deb_d = 0;
      rawq = '{1'b0, 1'b0};
      syncq.delete();
      return;
    end
    dead   = col || (y < YMIN) || (y > YMAX);
    p      = m_press;
    nst    = m_st;
    m_step = 0;
    m_jump = 0;
    case (m_st)
      0: begin m_pend = 0; if (st) nst = 1; end
      1: if (p) begin nst = 2; m_pend = 1; end
      2: begin
        if (pp && m_score < 255) m_score++;
        if (dead) nst = 3;
        else if (tk) begin
          if (m_pend || p) m_jump = 1; else m_step = 1;
          m_pend = 0;
        end else if (p) m_pend = 1;
      end
      default: if (ak) nst = 0;
    endcase
    if (nst == 0) begin m_score = 0; m_pend = 0; end
    m_st     = nst;
    m_preset = (nst <= 1);
    // Button: synced level is raw from two cycles back; flips after D differing samples
    s = rawq.pop_front();
    rawq.push_back(btn);
    syncq.push_back(s);
    if (syncq.size() > D) void'(syncq.pop_front());
    flip = (syncq.size() == D);
    foreach (syncq[i]) if (syncq[i] == m_deb) flip = 0;
    m_press = m_deb & ~m_deb_d;
    m_deb_d = m_deb;
    if (flip) m_deb = ~m_deb;
  endtask

  task automatic cyc(input bit rst, st, ak, btn, tk, col, pp, input int y);
    reset = rst; Start = st; Ack = ak; BtnRaw = btn;
    FrameTick = tk; Collide = col; PipePassed = pp; Bird_Y = y[9:0];
    @(posedge Clk);
    model_step(rst, st, ak, btn, tk, col, pp, y);
    #1;
    chk("q_Init",    int'(q_Init),    int'(m_st == 0));
    chk("q_Ready",   int'(q_Ready),   int'(m_st == 1));
    chk("q_Play",    int'(q_Play),    int'(m_st == 2));
    chk("q_Dead",    int'(q_Dead),    int'(m_st == 3));
    chk("PhysReset", int'(PhysReset), int'(m_preset));
    chk("PhysStep",  int'(PhysStep),  int'(m_step));
    chk("JumpReq",   int'(JumpReq),   int'(m_jump));
    chk("Score",     int'(Score),     m_score);
  endtask

  task automatic idle(input int n, input bit btn);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, btn, 0, 0, 0, 100);
  endtask

  task automatic goto_play();
    cyc(1, 0, 0, 0, 0, 0, 0, 100);
    cyc(0, 1, 0, 0, 0, 0, 0, 100);
    idle(10, 1);
    idle(8, 0);
    chk("goto_play", int'(q_Play), 1);
  endtask

  initial begin
    int first_play, jumps, steps, y;
    bit btn;

    // Reset and Start
    cyc(1, 0, 0, 0, 0, 0, 0, 100);
    chk("rst_init", int'(q_Init), 1);
    chk("rst_score", int'(Score), 0);
    idle(2, 0);
    cyc(0, 1, 0, 0, 0, 0, 0, 100);
    chk("start_ready", int'(q_Ready), 1);

    // Bounce shorter than D, then a clean hold
    for (int i = 0; i < 20; i++) cyc(0, 0, 0, ((i / 2) % 2) == 0, 0, 0, 0, 100);
    chk("bounce_no_press", int'(q_Ready), 1);
    first_play = -1;
    for (int j = 0; j < 12; j++) begin
      cyc(0, 0, 0, 1, 0, 0, 0, 100);
      if (q_Play && first_play < 0) first_play = j;
    end
    chk("press_latency", first_play, 7);
    idle(8, 0);

    // Ticks without presses; first tick consumes the READY press as a jump
    for (int i = 0; i < 60; i++) cyc(0, 0, 0, 0, (i % 10) == 0, 0, 0, 100);

    // Three presses between two ticks merge into one jump
    cyc(0, 0, 0, 0, 1, 0, 0, 100);
    for (int k = 0; k < 3; k++) begin idle(6, 1); idle(6, 0); end
    jumps = 0; steps = 0;
    cyc(0, 0, 0, 0, 1, 0, 0, 100);
    jumps += JumpReq; steps += PhysStep;
    idle(9, 0);
    cyc(0, 0, 0, 0, 1, 0, 0, 100);
    jumps += JumpReq; steps += PhysStep;
    chk("merge_jumps", jumps, 1);
    chk("merge_steps", steps, 1);

    // Collide on a tick
    cyc(0, 0, 0, 0, 1, 1, 0, 100);
    chk("collide_dead", int'(q_Dead), 1);
    chk("collide_nostep", int'(PhysStep | JumpReq), 0);
    idle(3, 0);
    cyc(0, 0, 1, 0, 0, 0, 0, 100);
    chk("ack_init", int'(q_Init), 1);

    // Bounds
    goto_play();
    cyc(0, 0, 0, 0, 0, 0, 0, 470);
    cyc(0, 0, 0, 0, 0, 0, 0, 471);
    chk("ymax_dead", int'(q_Dead), 1);
    goto_play();
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, -1);
    chk("ymin_dead", int'(q_Dead), 1);

    // Score saturation, death with PipePassed, PipePassed in DEAD, reset mid-play
    goto_play();
    for (int i = 0; i < 520; i++) cyc(0, 0, 0, 0, (i % 10) == 5, 0, i[0], 100);
    chk("score_sat", int'(Score), 255);
    goto_play();
    for (int i = 0; i < 6; i++) cyc(0, 0, 0, 0, 0, 0, 1, 100);
    cyc(0, 0, 0, 0, 0, 1, 1, 100);
    chk("pp_on_death", int'(Score), 7);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 1, 0, 1, 100);
    chk("pp_in_dead", int'(Score), 7);
    goto_play();
    cyc(0, 0, 0, 0, 0, 0, 1, 100);
    cyc(1, 0, 0, 1, 1, 0, 1, 100);
    chk("reset_mid", int'(q_Init), 1);

    // Randomized traffic
    btn = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(5, 0) == 0) btn = ~btn;
      y = int'($urandom_range(470, 0));
      case ($urandom_range(79, 0))
        0: y = -1;
        1: y = 471;
        2: y = 0;
        3: y = 470;
        default: ;
      endcase
      cyc($urandom_range(599, 0) == 0, $urandom_range(3, 0) == 0,
          $urandom_range(5, 0) == 0, btn, (i % 10) == 0,
          $urandom_range(99, 0) == 0, $urandom_range(7, 0) == 0, y);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/flappy_game_ctrl.md
# flappy_game_ctrl

Top-level game sequencer for Flappy-VGA. Turns the raw jump button into debounced single-cycle requests and gates the bird physics datapath to one update per VGA frame. Runs the INIT/READY/PLAY/DEAD game state machine from the Start/Ack handshake, collision and bounds inputs, and keeps the score. Sits between board I/O, the VGA timing block (FrameTick), the pipe/collision logic and the flight physics block.

## Interface
- DEBOUNCE_CYCLES, 500000: consecutive stable cycles needed before the debounced button level changes; legal range 2..2^20-1.
- Y_MIN, 0: lowest legal Bird_Y (signed 10-bit); Bird_Y < Y_MIN means dead.
- Y_MAX, 470: highest legal Bird_Y; Bird_Y > Y_MAX means dead.
- Clk  in  1  system clock.
- reset  in  1  synchronous, active-high.
- Start  in  1  level; leave INIT.
- Ack  in  1  level; leave DEAD.
- BtnRaw  in  1  asynchronous, bouncy button.
- FrameTick  in  1  one-cycle pulse per VGA frame.
- Collide  in  1  bird/pipe overlap, level, valid every cycle.
- PipePassed  in  1  one-cycle pulse when a pipe is cleared.
- Bird_Y  in  10 signed  current bird height from physics.
- PhysReset  out  1  holds physics in reset.
- PhysStep  out  1  one-cycle pulse: apply gravity step.
- JumpReq  out  1  one-cycle pulse: load jump velocity.
- Score  out  8  pipes passed, saturating.
- q_Init, q_Ready, q_Play, q_Dead  out  1 each  one-hot state flags.

## Operation
- Button path: 2-flop synchroniser, then debounce. The counter increments while the sync level differs from the debounced level and clears when they are equal. When the counter reaches DEBOUNCE_CYCLES-1 with the levels still differing, the debounced level takes the sync level and the counter clears. Press = registered rising edge of the debounced level, one cycle wide.
- INIT: PhysReset=1, Score cleared, pending jump cleared. Start=1 moves to READY.
- READY: PhysReset=1. Press moves to PLAY and sets the pending-jump flag.
- PLAY: PhysReset=0.
  - Press sets pending-jump. Repeated presses within a frame merge into one.
  - On a FrameTick: if pending, pulse JumpReq and clear pending; otherwise pulse PhysStep. The two pulses never overlap.
  - PipePassed increments Score, saturating at 255.
  - Collide=1, Bird_Y<Y_MIN or Bird_Y>Y_MAX moves to DEAD.
- DEAD: PhysStep and JumpReq held 0. Score and bird position frozen (PhysReset=0). Presses ignored. Ack=1 moves to INIT.
- Priority in PLAY: death condition beats FrameTick. In the cycle the death condition is sampled, no step or jump is issued.
- PipePassed outside PLAY is ignored. A PipePassed in the same cycle as a death condition still counts.
- Reset mid-game: next cycle is INIT, all flags and pulses follow reset values. The debouncer resets to level 0 with counter 0.

## Timing
- Reset values: state INIT, q_Init=1, other q_* 0, PhysReset=1, PhysStep=0, JumpReq=0, Score=0.
- All outputs are registered.
- State flags change 1 cycle after the triggering input is sampled.
- PhysStep/JumpReq assert in the cycle after FrameTick is sampled.
- Button latency: BtnRaw held high from cycle 0 gives debounced high at cycle 2+DEBOUNCE_CYCLES and the Press pulse at cycle 3+DEBOUNCE_CYCLES.
- A Press sampled in the same cycle as FrameTick is taken by that tick: JumpReq is issued.
- Score updates 1 cycle after PipePassed.
- A bounce shorter than DEBOUNCE_CYCLES produces no Press.

## Structure
- Shared package flappy_pkg:
  - state encoding localparams ST_INIT, ST_READY, ST_PLAY, ST_DEAD;
  - SCORE_W=8, POS_W=10;
  - default Y_MIN/Y_MAX.
- Sub-module button_debounce: synchroniser, counter and edge detector; ports Clk, reset, BtnRaw, Level, Press.
- Everything else is in flappy_game_ctrl.

## Test plan
- reset for 1 cycle -> q_Init=1, PhysReset=1, Score=0, no pulses. Start=1 -> q_Ready next cycle.
- DEBOUNCE_CYCLES=4; BtnRaw toggles every 2 cycles for 20 cycles, then held high -> no Press during bouncing; exactly one Press at 7 cycles after the hold starts; READY -> PLAY.
- In PLAY, FrameTick every 10 cycles, no presses -> PhysStep one cycle after each tick, JumpReq=0. Three presses between two ticks -> exactly one JumpReq at the next tick and no PhysStep at that tick.
- Collide=1 in the same cycle as FrameTick -> q_Dead next cycle, no PhysStep/JumpReq. Ack=1 -> INIT, Score cleared.
- Bird_Y=471 with Y_MAX=470 -> DEAD. Bird_Y=-1 with Y_MIN=0 -> DEAD.
- 260 PipePassed pulses in PLAY -> Score=255, held. PipePassed in DEAD -> no change. Reset asserted mid-PLAY -> reset values on the following cycle.
